// File: rtl/video_timing_gen.sv
`default_nettype none
// ==== video_timing_gen : raster sync / DE / coordinate generator | rev 1.0 ====
// Free-running h/v counters with a registered decode stage; everything advances only on ce.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          vblank,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Inclusive upper bounds keep every constant representable even when a total equals 2^CW.
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          de_q, de_d, vblank_q, vblank_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic          in_h_act, in_v_act, in_hs, in_vs;

  always_comb begin
    in_h_act      = (h_q <= H_ACT_LAST);
    in_v_act      = (v_q <= V_ACT_LAST);
    in_hs         = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    in_vs         = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    h_d           = h_q;
    v_d           = v_q;
    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    vblank_d      = vblank_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (ce) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
      de_d          = in_h_act && in_v_act;
      hsync_d       = in_hs ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = in_vs ? VSYNC_POL : ~VSYNC_POL;
      vblank_d      = !in_v_act;
      x_d           = (in_h_act && in_v_act) ? h_q : '0;
      y_d           = (in_h_act && in_v_act) ? v_q : '0;
      line_start_d  = (h_q == '0);
      frame_start_d = (h_q == '0) && (v_q == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q           <= '0;
      v_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      vblank_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      vblank_q      <= vblank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign vblank      = vblank_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin : g_width_check
    assert ((H_TOTAL <= (1 << CW)) && (V_TOTAL <= (1 << CW)))
      else $error("video_timing_gen: totals %0d/%0d exceed CW=%0d", H_TOTAL, V_TOTAL, CW);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// Scoreboard bench: three timing configurations share clk/ce/reset_n and are checked each cycle.
module tb_video_timing_gen;

  typedef struct packed {
    logic       hs, vs, de, vb, ls, fs;
    logic [9:0] x, y;
  } exp_t;
  typedef exp_t [2:0] trio_t;

  localparam int HA [3] = '{640, 8, 20};
  localparam int HF [3] = '{16, 2, 3};
  localparam int HS [3] = '{96, 2, 5};
  localparam int HB [3] = '{48, 2, 4};
  localparam int VA [3] = '{480, 4, 10};
  localparam int VF [3] = '{10, 1, 2};
  localparam int VS [3] = '{2, 1, 3};
  localparam int VB [3] = '{33, 1, 4};
  localparam bit HP [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit VP [3] = '{1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic ce = 1'b0;
  always #5 clk = ~clk;

  logic       hs0, vs0, de0, vb0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       hs1, vs1, de1, vb1, ls1, fs1;
  logic [3:0] x1, y1;
  logic       hs2, vs2, de2, vb2, ls2, fs2;
  logic [4:0] x2, y2;

  video_timing_gen u_dut0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .hsync(hs0), .vsync(vs0), .de(de0), .vblank(vb0),
    .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0));

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(4)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .hsync(hs1), .vsync(vs1), .de(de1), .vblank(vb1),
    .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1));

  // H_TOTAL = 32 = 2^CW: exercises the full-width counter boundary.
  video_timing_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4), .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(4),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(5)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .hsync(hs2), .vsync(vs2), .de(de2), .vblank(vb2),
    .x(x2), .y(y2), .line_start(ls2), .frame_start(fs2));

  int    tests = 0;
  int    fails = 0;
  trio_t sbq[$];
  trio_t mon_item;
  exp_t  last[3];
  int    pos[3];
  bit    period_en = 1'b0;
  int    cyc = 0;
  int    last_fs1 = -1;
  int    last_ls0 = -1;
  logic  fs1_prev = 1'b0;
  logic  ls0_prev = 1'b0;

  function automatic int htot(int d);
    return HA[d] + HF[d] + HS[d] + HB[d];
  endfunction

  function automatic int ftot(int d);
    return htot(d) * (VA[d] + VF[d] + VS[d] + VB[d]);
  endfunction

  // Reference: raster position p (pixels since frame start) -> outputs.
  function automatic exp_t model(int d, int p);
    exp_t e;
    int   h, v;
    h    = p % htot(d);
    v    = p / htot(d);
    e.de = (h < HA[d]) && (v < VA[d]);
    e.hs = ((h >= HA[d] + HF[d]) && (h < HA[d] + HF[d] + HS[d])) ? HP[d] : !HP[d];
    e.vs = ((v >= VA[d] + VF[d]) && (v < VA[d] + VF[d] + VS[d])) ? VP[d] : !VP[d];
    e.vb = (v >= VA[d]);
    e.x  = e.de ? 10'(h) : 10'd0;
    e.y  = e.de ? 10'(v) : 10'd0;
    e.ls = (h == 0);
    e.fs = (p == 0);
    return e;
  endfunction

  function automatic exp_t reset_exp(int d);
    exp_t e;
    e    = '0;
    e.hs = !HP[d];
    e.vs = !VP[d];
    return e;
  endfunction

  function automatic exp_t act(int d);
    exp_t a;
    a = '0;
    case (d)
      0: a = {hs0, vs0, de0, vb0, ls0, fs0, x0, y0};
      1: a = {hs1, vs1, de1, vb1, ls1, fs1, 6'd0, x1, 6'd0, y1};
      default: a = {hs2, vs2, de2, vb2, ls2, fs2, 5'd0, x2, 5'd0, y2};
    endcase
    return a;
  endfunction

  task automatic check(string nm, int d, exp_t a, exp_t e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t: got hs%b vs%b de%b vb%b ls%b fs%b x%0d y%0d, expected hs%b vs%b de%b vb%b ls%b fs%b x%0d y%0d",
               nm, d, $time, a.hs, a.vs, a.de, a.vb, a.ls, a.fs, a.x, a.y,
               e.hs, e.vs, e.de, e.vb, e.ls, e.fs, e.x, e.y);
    end
  endtask

  task automatic check_int(string nm, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // Advance the model on a clock edge and queue what the DUTs must show afterwards.
  task automatic edge_push();
    trio_t t;
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (!reset_n) begin
        last[d] = reset_exp(d);
        pos[d]  = 0;
      end else if (ce) begin
        last[d] = model(d, pos[d]);
        pos[d]  = (pos[d] + 1) % ftot(d);
      end
      t[d] = last[d];
    end
    sbq.push_back(t);
  endtask

  task automatic cycle(bit cev, bit rstv);
    @(negedge clk);
    ce      = cev;
    reset_n = rstv;
    edge_push();
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check("async_reset", d, act(d), reset_exp(d));
    edge_push();
    cycle(1'($urandom_range(0, 1)), 1'b0);
    cycle(1'b1, 1'b1);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (sbq.size() > 0) begin
        mon_item = sbq.pop_front();
        for (int d = 0; d < 3; d++) check("scoreboard", d, act(d), mon_item[d]);
      end
      if (period_en) begin
        if (fs1 && !fs1_prev) begin
          if (last_fs1 >= 0) check_int("frame_period_dut1", cyc - last_fs1, 98);
          last_fs1 = cyc;
        end
        if (ls0 && !ls0_prev) begin
          if (last_ls0 >= 0) check_int("line_period_dut0", cyc - last_ls0, 800);
          last_ls0 = cyc;
        end
      end
      fs1_prev = fs1;
      ls0_prev = ls0;
    end
  end

  initial begin : driver
    for (int d = 0; d < 3; d++) begin
      last[d] = reset_exp(d);
      pos[d]  = 0;
    end
    #1 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check("reset_state", d, act(d), reset_exp(d));
    repeat (3) cycle(1'b1, 1'b0);

    // Continuous ce: strobes single-cycle, periods checked directly as well.
    period_en = 1'b1;
    cycle(1'b1, 1'b1);
    repeat (2500) cycle(1'b1, 1'b1);
    period_en = 1'b0;

    // Alternating ce: outputs hold on every ce=0 edge.
    for (int i = 0; i < 1600; i++) cycle(1'(i % 2), 1'b1);

    // Random ce density with random mid-frame resets.
    for (int k = 0; k < 20; k++) begin
      int len;
      len = int'($urandom_range(50, 600));
      for (int i = 0; i < len; i++) cycle(($urandom_range(0, 3) != 0), 1'b1);
      mid_reset();
    end

    repeat (4) @(negedge clk);
    check_int("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
